calc_cu: RTL
============

Name: calc_cu

Overview:
- Control unit sitting directly upstream of the 4-bit calculator datapath (top_DP).
- Accepts a one-cycle start request plus a 3-bit opcode, then sequences the datapath control word (load, execute, output-mux select, output-register enable) until the result is latched.
- Handles the multi-cycle divider handshake and the divide-by-zero case.
- Reports busy, done and err to the enclosing top level.

Parameters:
- MAX_WAIT, 15: cycle limit on waiting for done_calc or done_div. Used only when CU_WATCHDOG_EN is defined.
- CW, 4: width of the wait counter; must satisfy MAX_WAIT < 2^CW.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- go  in  1  start request, sampled in IDLE only.
- op  in  3  opcode: 000 add, 001 sub, 010 and, 011 xor, 100 div, 101 mul, 110 passA, 111 passB.
- y_zero  in  1  high when the datapath's loaded y register equals 0.
- done_calc  in  1  calculator-unit completion.
- done_div  in  1  divider completion.
- en_x, en_y  out  1 each  load x / y operand registers.
- go_calc, go_div, go_mult  out  1 each  start the calc / div / mult unit.
- sel_h  out  1  high-output mux select.
- sel_l  out  2  low-output mux select: 00 zero, 01 calc, 10 mult, 11 div.
- en_out_h, en_out_l  out  1 each  output-register enables.
- op_calc  out  3  opcode to the datapath.
- busy  out  1  high whenever the state is not IDLE.
- done  out  1  one-cycle completion pulse.
- err  out  1  sticky divide-by-zero / timeout flag.

Behaviour:
- Moore machine. All outputs decode from the state register and op_r (opcode captured on accept). Default value of every output is 0.
- Reset: asynchronous, effective immediately, including mid-operation. State goes to IDLE; op_r, wait counter and err clear to 0; all outputs read 0 while rst is high.
- IDLE: if go=1, capture op into op_r, clear err, and go to LOAD. go is ignored in every other state.
- LOAD: en_x=en_y=1 for exactly one cycle. Next state is CHECK.
- CHECK: no outputs asserted. Branches:
  - op_r=100 and y_zero=1: go to ERR.
  - op_r in 000..011: go to CALC.
  - op_r=100: go to DIV.
  - op_r=101: go to MUL.
  - op_r in 11x: go to PASS.
- CALC: go_calc=1, op_calc=op_r. Holds until done_calc=1, then MUX_C.
- DIV: go_div=1, op_calc=100. Holds until done_div=1, then MUX_D.
- MUL: go_mult=1, op_calc=101 for one cycle. Next state is MUX_M.
- PASS: op_calc=op_r for one cycle. Next state is OUT_L.
- MUX_C: sel_l=01. Next state is OUT_L.
- MUX_D: sel_h=1, sel_l=11. Next state is OUT_HL.
- MUX_M: sel_l=10. Next state is OUT_HL.
- Mux selects and op_calc from the preceding state are held through the following OUT state.
- OUT_L: en_out_l=1 for one cycle. Next state is DONE.
- OUT_HL: en_out_h=en_out_l=1 for one cycle. Next state is DONE.
- DONE: done=1 for one cycle. Next state is IDLE.
- ERR: en_out_h=en_out_l=1 with sel_h=0, sel_l=00, which clears both outputs to 0. err is set. Next state is DONE.
- err stays high until the next accepted go or reset.
- Latency from go sampled to done pulse, with done_* arriving in the first wait cycle:
  - add: 6 cycles.
  - mul: 6 cycles.
  - pass: 5 cycles.
  - div-by-zero: 4 cycles.
  - div: 6 + (extra wait cycles) cycles.
- done_calc or done_div asserted outside its wait state is ignored.
- go held high continuously starts a new operation on the cycle after DONE, i.e. from IDLE.

Optional Feature:
- CU_WATCHDOG_EN defined:
  - CW-bit counter clears on entry to CALC or DIV and increments each cycle spent waiting there.
  - If the counter reaches MAX_WAIT without a done_*, go to ERR (outputs cleared, err set, then DONE).
- Not defined: no counter; CALC and DIV wait indefinitely; MAX_WAIT and CW are unused.

Test Plan:
- Add 14+3: go=1, op=000, y_zero=0, done_calc high in the first CALC cycle.
  - Control sequence is LOAD(en_x, en_y), CHECK, CALC(go_calc, op_calc=000), MUX_C(sel_l=01), OUT_L(en_out_l), DONE.
  - done pulses 6 cycles after go; err=0; busy falls with the return to IDLE.
- Div 14/5: op=100, done_div asserted after 5 DIV cycles.
  - go_div high for exactly 5 cycles; MUX_D shows sel_h=1, sel_l=11; OUT_HL asserts both enables; done follows.
- Div by zero: op=100, y_zero=1.
  - No go_div is ever asserted; ERR asserts both enables with sel_l=00; err=1 and stays high after DONE.
  - A following add clears err on accept.
- Mul and passA: op=101 gives go_mult for 1 cycle, then sel_l=10, then OUT_HL.
  - op=110 gives op_calc=110 for 2 cycles, then OUT_L, with no go_* asserted.
- Reset in DIV (3rd wait cycle), then go pulsed while busy:
  - After rst: all outputs 0 immediately and state IDLE.
  - go asserted during LOAD of a new operation is ignored.
- With CU_WATCHDOG_EN and MAX_WAIT=15: op=000 with done_calc held at 0.
  - go_calc is high for 15 cycles, then ERR, err=1, then done.
  - Without the macro, the unit stays in CALC indefinitely.

Source files
------------

// File: rtl/calc_cu.sv
// Control unit that sequences the 4-bit calculator datapath for one opcode per go request.
// Build with CU_WATCHDOG_EN defined to bound the calc/div wait by MAX_WAIT cycles.
`timescale 1ns / 1ps

module calc_cu #(
  parameter int unsigned MAX_WAIT = 15,
  parameter int unsigned CW       = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       go,
  input  logic [2:0] op,
  input  logic       y_zero,
  input  logic       done_calc,
  input  logic       done_div,
  output logic       en_x,
  output logic       en_y,
  output logic       go_calc,
  output logic       go_div,
  output logic       go_mult,
  output logic       sel_h,
  output logic [1:0] sel_l,
  output logic       en_out_h,
  output logic       en_out_l,
  output logic [2:0] op_calc,
  output logic       busy,
  output logic       done,
  output logic       err
);

  typedef enum logic [3:0] {
    StIdle, StLoad, StCheck, StCalc, StDiv, StMul, StPass,
    StMuxC, StMuxD, StMuxM, StOutL, StOutHl, StDone, StErr
  } state_e;

  state_e     state_q, state_d;
  logic [2:0] op_q, op_d;
  logic       err_q, err_d;

  if (MAX_WAIT >= (1 << CW)) begin : g_cfg_check
    $error("MAX_WAIT must be below 2**CW");
  end

`ifdef CU_WATCHDOG_EN
  logic [CW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      op_q    <= 3'b000;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    err_d   = err_q;
`ifdef CU_WATCHDOG_EN
    cnt_d   = cnt_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (go) begin
          op_d    = op;
          err_d   = 1'b0;
          state_d = StLoad;
        end
      end
      StLoad: state_d = StCheck;
      StCheck: begin
`ifdef CU_WATCHDOG_EN
        cnt_d = '0;
`endif
        if (op_q == 3'b100 && y_zero) state_d = StErr;
        else if (!op_q[2])            state_d = StCalc;
        else if (op_q[1])             state_d = StPass;
        else if (op_q[0])             state_d = StMul;
        else                          state_d = StDiv;
      end
      StCalc: begin
        if (done_calc) state_d = StMuxC;
`ifdef CU_WATCHDOG_EN
        else if (cnt_q == CW'(MAX_WAIT - 1)) state_d = StErr;
        else cnt_d = cnt_q + 1'b1;
`endif
      end
      StDiv: begin
        if (done_div) state_d = StMuxD;
`ifdef CU_WATCHDOG_EN
        else if (cnt_q == CW'(MAX_WAIT - 1)) state_d = StErr;
        else cnt_d = cnt_q + 1'b1;
`endif
      end
      StMul:   state_d = StMuxM;
      StPass:  state_d = StOutL;
      StMuxC:  state_d = StOutL;
      StMuxD:  state_d = StOutHl;
      StMuxM:  state_d = StOutHl;
      StOutL:  state_d = StDone;
      StOutHl: state_d = StDone;
      StErr:   state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
    // err is visible from the ERR cycle onward
    if (state_d == StErr) err_d = 1'b1;
  end

  always_comb begin
    en_x     = 1'b0;
    en_y     = 1'b0;
    go_calc  = 1'b0;
    go_div   = 1'b0;
    go_mult  = 1'b0;
    sel_h    = 1'b0;
    sel_l    = 2'b00;
    en_out_h = 1'b0;
    en_out_l = 1'b0;
    op_calc  = 3'b000;
    done     = 1'b0;
    unique case (state_q)
      StLoad: begin
        en_x = 1'b1;
        en_y = 1'b1;
      end
      StCalc: begin
        go_calc = 1'b1;
        op_calc = op_q;
      end
      StDiv: begin
        go_div  = 1'b1;
        op_calc = 3'b100;
      end
      StMul: begin
        go_mult = 1'b1;
        op_calc = 3'b101;
      end
      StPass: op_calc = op_q;
      StMuxC: sel_l = 2'b01;
      StMuxD: begin
        sel_h = 1'b1;
        sel_l = 2'b11;
      end
      StMuxM: sel_l = 2'b10;
      // OUT states keep whatever the preceding state drove: PASS or MUX_C for OUT_L
      StOutL: begin
        en_out_l = 1'b1;
        if (op_q[2]) op_calc = op_q;
        else         sel_l   = 2'b01;
      end
      StOutHl: begin
        en_out_h = 1'b1;
        en_out_l = 1'b1;
        if (op_q[0]) begin
          sel_l = 2'b10;
        end else begin
          sel_h = 1'b1;
          sel_l = 2'b11;
        end
      end
      StErr: begin
        en_out_h = 1'b1;
        en_out_l = 1'b1;
      end
      StDone: done = 1'b1;
      default: ;
    endcase
  end

  assign busy = (state_q != StIdle);
  assign err  = err_q;

endmodule
